// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core fetch port. The program image is loaded at run time
// from a little-endian byte stream, and the core is held in reset until the load completes.
module inst_rom_loader #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic [DEPTH_LOG2:0]   load_len_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  input  logic [31:0]           inst_addr_i,
  output logic [31:0]           inst_o,
  output logic                  core_rst_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  err_o
);
  localparam int            DEPTH   = 1 << DEPTH_LOG2;
  localparam int            LW      = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                r_state, w_next;
  logic [LW-1:0]         r_word_cnt, r_target_len, r_loaded_len;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_asm;
  logic                  r_err, r_load_done;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept, w_last, w_start_load, w_start_run, w_fetch_ok;
  logic [LW-1:0]         w_len;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign w_len    = (load_len_i > DEPTH_L) ? DEPTH_L : load_len_i;
  assign w_accept = byte_valid_i && (r_state == S_LOAD);
  assign w_last   = w_accept && (r_byte_cnt == 2'd3) && (r_word_cnt == r_target_len - LW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A zero-length start from RUN re-enters RUN with an empty image rather than
  // parking in LOAD waiting for a word that never comes.
  always_comb begin
    w_next       = r_state;
    w_start_load = 1'b0;
    w_start_run  = 1'b0;
    case (r_state)
      S_IDLE, S_RUN: begin
        if (load_start_i) begin
          if (w_len == '0) begin
            w_next      = S_RUN;
            w_start_run = 1'b1;
          end else begin
            w_next       = S_LOAD;
            w_start_load = 1'b1;
          end
        end
      end
      S_LOAD:  if (w_last) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_idx      = inst_addr_i[DEPTH_LOG2+1:2];
  assign w_fetch_ok = (r_state == S_RUN) && (inst_addr_i[1:0] == 2'b00) &&
                      (inst_addr_i[31:DEPTH_LOG2+2] == '0) && ({1'b0, w_idx} < r_loaded_len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_target_len <= '0;
      r_loaded_len <= '0;
      r_asm        <= '0;
      r_err        <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= w_last;
      if (w_start_load) begin
        r_word_cnt   <= '0;
        r_byte_cnt   <= '0;
        r_err        <= 1'b0;
        r_loaded_len <= '0;
        r_target_len <= w_len;
      end else begin
        if (w_start_run) r_loaded_len <= '0;
        if ((r_state == S_RUN) && !w_fetch_ok) r_err <= 1'b1;
        if (w_accept) begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          case (r_byte_cnt)
            2'd0:    r_asm[7:0]   <= byte_data_i;
            2'd1:    r_asm[15:8]  <= byte_data_i;
            2'd2:    r_asm[23:16] <= byte_data_i;
            default: ;
          endcase
          if (r_byte_cnt == 2'd3) r_word_cnt <= r_word_cnt + LW'(1);
        end
        if (w_last) r_loaded_len <= r_target_len;
      end
    end
  end

  // Image storage is deliberately not reset; loaded_len gates every read.
  always_ff @(posedge clk) begin
    if (w_accept && (r_byte_cnt == 2'd3))
      r_mem[r_word_cnt[DEPTH_LOG2-1:0]] <= {byte_data_i, r_asm};
  end

  assign inst_o       = w_fetch_ok ? r_mem[w_idx] : NOP_INST;
  assign byte_ready_o = (r_state == S_LOAD);
  assign busy_o       = (r_state == S_LOAD);
  assign core_rst_o   = (r_state != S_RUN);
  assign load_done_o  = r_load_done;
  assign err_o        = r_err;
endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized bench for inst_rom_loader against an address-level model of the loaded image.
module tb_inst_rom_loader;
  localparam int          DL    = 4;
  localparam int          DEPTH = 1 << DL;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        load_start_i = 1'b0, byte_valid_i = 1'b0;
  logic [DL:0] load_len_i = '0;
  logic [7:0]  byte_data_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        byte_ready_o, core_rst_o, busy_o, load_done_o, err_o;
  logic [31:0] inst_o;

  inst_rom_loader #(.DEPTH_LOG2(DL), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .load_start_i(load_start_i), .load_len_i(load_len_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o),
    .inst_addr_i(inst_addr_i), .inst_o(inst_o), .core_rst_o(core_rst_o),
    .busy_o(busy_o), .load_done_o(load_done_o), .err_o(err_o));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] m_mem [DEPTH];
  int          m_len = 0;
  logic        m_run = 1'b0, m_err = 1'b0;
  logic [7:0]  q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return m_run && (a[1:0] == 2'b00) && (a < DEPTH * 4) && ((a >> 2) < m_len);
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (addr_ok(a)) return m_mem[a >> 2];
    return NOP;
  endfunction

  // Every RUN cycle with a bad fetch address latches the model error flag.
  task automatic step();
    if (m_run && !addr_ok(inst_addr_i)) m_err = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic fetch(input string tag, input logic [31:0] a);
    inst_addr_i = a; #1;
    chk({tag, "_inst"}, inst_o, exp_inst(a));
    step();
    chk({tag, "_err"}, err_o, m_err);
  endtask

  task automatic do_load(input int len, input int gap_mode);
    int tgt;
    int gaps;
    logic [7:0] b;
    logic [31:0] w;
    tgt = (len > DEPTH) ? DEPTH : len;
    load_start_i = 1'b1; load_len_i = len[DL:0];
    step();
    load_start_i = 1'b0;
    m_err = 1'b0; m_len = 0; m_run = (tgt == 0);
    if (tgt == 0) begin
      chk("len0_core_rst", core_rst_o, 0);
      chk("len0_busy", busy_o, 0);
      return;
    end
    chk("ld_busy", busy_o, 1);
    chk("ld_core_rst", core_rst_o, 1);
    chk("ld_err_clr", err_o, 0);
    for (int wi = 0; wi < tgt; wi++) begin
      w = '0;
      for (int bi = 0; bi < 4; bi++) begin
        gaps = (gap_mode == 1) ? (((wi * 4 + bi) % 3 == 2) ? 3 : 1) :
               (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gaps; g++) begin
          byte_valid_i = 1'b0; byte_data_i = 8'($urandom);
          step();
          chk("gap_ready", byte_ready_o, 1);
        end
        if (q.size() > 0) b = q.pop_front();
        else b = 8'($urandom);
        w[bi*8 +: 8] = b;
        byte_valid_i = 1'b1; byte_data_i = b;
        step();
      end
      m_mem[wi] = w;
    end
    byte_valid_i = 1'b0;
    m_len = tgt; m_run = 1'b1;
    chk("done_pulse", load_done_o, 1);
    chk("run_core_rst", core_rst_o, 0);
    chk("run_ready", byte_ready_o, 0);
    step();
    chk("done_once", load_done_o, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; #1;
    chk("rst_core_rst", core_rst_o, 1);
    chk("rst_ready", byte_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    m_run = 1'b0; m_len = 0; m_err = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] a;
    int t;
    // 1: reset state
    #1 do_reset();
    inst_addr_i = 32'h0; #1;
    chk("rst_inst", inst_o, NOP);
    chk("rst_err", err_o, 0);
    chk("rst_done", load_done_o, 0);

    // 2: directed two-word load
    q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    do_load(2, 0);
    chk("img_w0", m_mem[0], 32'h00100093);
    fetch("t2_a0", 32'h0);
    fetch("t2_a4", 32'h4);
    fetch("t2_a8", 32'h8);
    chk("t2_err_set", err_o, 1);

    // 3: same image with a gappy stream
    inst_addr_i = 32'h0;
    q = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    do_load(2, 1);
    fetch("t3_a0", 32'h0);
    inst_addr_i = 32'h4; #1;
    chk("t3_a4_direct", inst_o, 32'h00200113);

    // 4: misaligned / out-of-range fetch, then a new load clears err
    fetch("t4_mis", 32'h2);
    fetch("t4_oor", DEPTH * 4);
    chk("t4_err_set", err_o, 1);
    inst_addr_i = 32'h0;
    do_load(1, 0);

    // 5: reset in the middle of a load
    load_start_i = 1'b1; load_len_i = 2;
    step();
    load_start_i = 1'b0; m_run = 1'b0; m_err = 1'b0; m_len = 0;
    for (int i = 0; i < 5; i++) begin
      byte_valid_i = 1'b1; byte_data_i = 8'($urandom);
      step();
    end
    byte_valid_i = 1'b0;
    do_reset();
    q = '{8'h13, 8'h05, 8'h00, 8'h00};
    do_load(1, 0);
    fetch("t5_a0", 32'h0);
    chk("t5_a0_lit", exp_inst(32'h0), 32'h00000513);
    fetch("t5_a4", 32'h4);

    // 6: zero-length and over-length loads
    do_reset();
    inst_addr_i = 32'h0;
    do_load(0, 0);
    fetch("t6_len0_a0", 32'h0);
    chk("t6_len0_err", err_o, 1);
    do_load(DEPTH + 5, 0);
    byte_valid_i = 1'b1; byte_data_i = 8'hAA; #1;
    chk("t6_no_extra", byte_ready_o, 0);
    step();
    byte_valid_i = 1'b0;
    chk("t6_still_run", core_rst_o, 0);
    fetch("t6_last", (DEPTH - 1) * 4);
    fetch("t6_past", DEPTH * 4);

    // randomized loads and fetches
    for (int it = 0; it < 6; it++) begin
      inst_addr_i = 32'h0;
      do_load(int'($urandom_range(1, DEPTH + 3)), 2);
      for (int k = 0; k < 12; k++) begin
        t = int'($urandom_range(0, 3));
        case (t)
          0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
          1:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
          2:       a = DEPTH * 4 + 32'($urandom_range(0, 255));
          default: a = $urandom;
        endcase
        fetch("rnd", a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
